// File: rtl/enemy_wave_controller_pkg.sv
// Shared types and constants for the enemy wave controller.
package enemy_wave_controller_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam int N_SLOTS = 10;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [7:0] X_MAX = 8'd143;

  // Number of set bits in a slot mask.
  function automatic logic [3:0] count_ones(input logic [N_SLOTS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Folds a raw LFSR byte into the visible x range 0..X_MAX.
  function automatic logic [7:0] fold_x(input logic [7:0] raw);
    return (raw > X_MAX) ? (raw - 8'd128) : raw;
  endfunction

endpackage

// File: rtl/enemy_wave_controller_slot_allocator.sv
// Picks the lowest-index free slot from a free mask.
module enemy_wave_controller_slot_allocator
  import enemy_wave_controller_pkg::*;
(
  input  logic [N_SLOTS-1:0] free_mask,
  output logic               found,
  output logic [3:0]         slot
);

  // Scan from the top down so the lowest free index is the one left standing.
  always_comb begin
    found = 1'b0;
    slot  = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        found = 1'b1;
        slot  = 4'(i);
      end
    end
  end

endmodule

// File: rtl/enemy_wave_controller.sv
// Game sequencer for the ten enemy slots: spawning, retiring, scoring and game state.
module enemy_wave_controller
  import enemy_wave_controller_pkg::*;
#(
  parameter int          SPAWN_TICKS     = 50_000_000,
  parameter int          KILLS_PER_LEVEL = 8,
  parameter int          MAX_MISSES      = 3,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [N_SLOTS-1:0]   hit,
  input  logic [N_SLOTS-1:0]   touch_edge,
  output logic [N_SLOTS-1:0]   c_en,
  output logic [N_SLOTS-1:0]   des,
  output logic                 move_en,
  output logic [1:0]           flying_rate,
  output logic                 spawn_valid,
  output logic [3:0]           spawn_slot,
  output logic [7:0]           spawn_x,
  output logic [7:0]           kills,
  output logic [1:0]           misses,
  output logic                 game_over
);

  localparam logic [4:0] MISS_LIMIT = 5'(MAX_MISSES);

  state_t             state;
  state_t             state_next;
  logic               begin_game;
  logic               end_game;
  logic               in_play;
  logic [N_SLOTS-1:0] retire;
  logic [N_SLOTS-1:0] kill_mask;
  logic [N_SLOTS-1:0] miss_mask;
  logic [N_SLOTS-1:0] free_mask;
  logic [N_SLOTS-1:0] launch_mask;
  logic [8:0]         kill_total;
  logic [4:0]         miss_total;
  logic [7:0]         kills_next;
  logic [1:0]         misses_next;
  logic [7:0]         kills_div;
  logic [1:0]         level_calc;
  logic [1:0]         level;
  logic [31:0]        timer;
  logic [31:0]        reload;
  logic               pending;
  logic               expire;
  logic               launch;
  logic               found;
  logic [3:0]         free_slot;
  logic [15:0]        lfsr;

  enemy_wave_controller_slot_allocator u_alloc (
    .free_mask (free_mask),
    .found     (found),
    .slot      (free_slot)
  );

  // Slot events, counter arithmetic and the launch decision for this cycle.
  always_comb begin
    in_play     = (state == PLAY);
    retire      = in_play ? (c_en & (hit | touch_edge)) : '0;
    kill_mask   = retire & hit;
    miss_mask   = retire & touch_edge & ~hit;
    kill_total  = {1'b0, kills} + {5'b00000, count_ones(kill_mask)};
    kills_next  = kill_total[8] ? 8'hFF : kill_total[7:0];
    miss_total  = {3'b000, misses} + {1'b0, count_ones(miss_mask)};
    misses_next = (miss_total >= MISS_LIMIT) ? MISS_LIMIT[1:0] : miss_total[1:0];
    kills_div   = kills / 8'(KILLS_PER_LEVEL);
    level_calc  = (kills_div > 8'd3) ? 2'd3 : kills_div[1:0];
    reload      = 32'(SPAWN_TICKS) >> level;
    expire      = in_play && (timer <= 32'd1);
    free_mask   = ~c_en & ~des & ~retire;
    launch      = in_play && !end_game && pending && found;
    launch_mask = launch ? (10'(1) << free_slot) : '0;
  end

  // Next-state logic for IDLE / PLAY / GAME_OVER.
  always_comb begin
    state_next = state;
    begin_game = 1'b0;
    end_game   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = PLAY;
          begin_game = 1'b1;
        end
      end
      PLAY: begin
        if (miss_total >= MISS_LIMIT) begin
          state_next = GAME_OVER;
          end_game   = 1'b1;
        end
      end
      GAME_OVER: begin
        if (start) begin
          state_next = PLAY;
          begin_game = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Slot enables, clear pulses and the launch report.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c_en        <= '0;
      des         <= '0;
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_x     <= '0;
    end else begin
      spawn_valid <= launch;
      if (launch) begin
        spawn_slot <= free_slot;
        spawn_x    <= fold_x(lfsr[7:0]);
      end
      if (begin_game) begin
        c_en <= '0;
        des  <= '1;
      end else if (end_game) begin
        c_en <= '0;
        des  <= c_en;
      end else begin
        c_en <= (c_en & ~retire) | launch_mask;
        des  <= retire;
      end
    end
  end

  // Kill/miss counters and the level derived from kills one cycle later.
  always_ff @(posedge clk) begin
    if (!reset_n || begin_game) begin
      kills  <= '0;
      misses <= '0;
      level  <= '0;
    end else begin
      kills  <= kills_next;
      misses <= misses_next;
      level  <= level_calc;
    end
  end

  // Spawn timer expires as it steps from 1 to 0, so the period equals the reload value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer   <= '0;
      pending <= 1'b0;
    end else if (begin_game) begin
      timer   <= 32'(SPAWN_TICKS);
      pending <= 1'b0;
    end else if (in_play) begin
      timer <= expire ? reload : (timer - 32'd1);
      if (expire)      pending <= 1'b1;
      else if (launch) pending <= 1'b0;
    end
  end

  // Free-running x-position LFSR.
  always_ff @(posedge clk) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign move_en     = (state == PLAY);
  assign game_over   = (state == GAME_OVER);
  assign flying_rate = level;

endmodule
